// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep controller: runs a 5-bit counter lo -> hi -> lo for a programmed pass count.
// Optional abort input is compiled in when UPDOWN_SWEEP_ABORT_EN is defined.
`timescale 1ns/1ps

module updown_sweep_ctrl #(
    parameter int WIDTH  = 5,
    parameter int PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [PASS_W-1:0] passes,
    input  logic              hold,
`ifdef UPDOWN_SWEEP_ABORT_EN
    input  logic              abort,
`endif
    output logic [WIDTH-1:0]  dout,
    output logic              mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] pass_cnt
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    localparam logic [WIDTH-1:0]  ONE_W = 1;
    localparam logic [PASS_W-1:0] ONE_P = 1;

    state_t              state, state_nx;
    logic [WIDTH-1:0]    lo_r, hi_r, lo_nx, hi_nx, dout_nx;
    logic [PASS_W-1:0]   passes_r, passes_nx, pass_cnt_nx, pass_inc;
    logic                mode_nx, busy_nx, done_nx, err_nx;
    logic                abort_req;

`ifdef UPDOWN_SWEEP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign pass_inc = pass_cnt + ONE_P;

    // NOTE: every signal gets its hold-value default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx    = state;
        lo_nx       = lo_r;
        hi_nx       = hi_r;
        passes_nx   = passes_r;
        dout_nx     = dout;
        mode_nx     = mode;
        busy_nx     = busy;
        pass_cnt_nx = pass_cnt;
        done_nx     = 1'b0;
        err_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if ((lo < hi) && (passes != '0)) begin
                        lo_nx       = lo;
                        hi_nx       = hi;
                        passes_nx   = passes;
                        dout_nx     = lo;
                        pass_cnt_nx = '0;
                        mode_nx     = 1'b0;
                        busy_nx     = 1'b1;
                        state_nx    = UP;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end

            UP, DOWN: begin
                // Abort outranks hold so a frozen sweep can still be terminated.
                if (abort_req) begin
                    state_nx = DONE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    mode_nx  = 1'b0;
                end else if (!hold) begin
                    if (state == UP) begin
                        if (dout < hi_r) begin
                            dout_nx = dout + ONE_W;
                        end else begin
                            dout_nx  = hi_r - ONE_W;
                            mode_nx  = 1'b1;
                            state_nx = DOWN;
                        end
                    end else begin
                        if (dout > lo_r) begin
                            dout_nx = dout - ONE_W;
                        end else begin
                            pass_cnt_nx = pass_inc;
                            if (pass_inc == passes_r) begin
                                state_nx = DONE;
                                busy_nx  = 1'b0;
                                done_nx  = 1'b1;
                                mode_nx  = 1'b0;
                            end else begin
                                state_nx = UP;
                                mode_nx  = 1'b0;
                                dout_nx  = lo_r + ONE_W;
                            end
                        end
                    end
                end
            end

            DONE: state_nx = IDLE;

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lo_r     <= '0;
            hi_r     <= '0;
            passes_r <= '0;
            dout     <= '0;
            mode     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
        end else begin
            state    <= state_nx;
            lo_r     <= lo_nx;
            hi_r     <= hi_nx;
            passes_r <= passes_nx;
            dout     <= dout_nx;
            mode     <= mode_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            err      <= err_nx;
            pass_cnt <= pass_cnt_nx;
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed self-checking bench for updown_sweep_ctrl; abort steps run when UPDOWN_SWEEP_ABORT_EN is defined.
`timescale 1ns/1ps

module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, hold, abort;
    logic [4:0] lo, hi, dout;
    logic [3:0] passes, pass_cnt;
    logic       mode, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    updown_sweep_ctrl #(.WIDTH(5), .PASS_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .lo       (lo),
        .hi       (hi),
        .passes   (passes),
        .hold     (hold),
`ifdef UPDOWN_SWEEP_ABORT_EN
        .abort    (abort),
`endif
        .dout     (dout),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .pass_cnt (pass_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int basic_dout[13] = '{3, 4, 5, 6, 5, 4, 3, 4, 5, 6, 5, 4, 3};
        int basic_mode[13] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        int n;
        int max_dout;

        reset = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
        lo = '0; hi = '0; passes = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_dout", dout, 0);
        check("rst_mode", mode, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_pass_cnt", pass_cnt, 0);

        // Basic two-pass sweep 3..6
        lo = 5'd3; hi = 5'd6; passes = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            check("basic_dout", dout, basic_dout[i]);
            check("basic_mode", mode, basic_mode[i]);
            check("basic_busy", busy, 1);
            check("basic_done", done, 0);
            check("basic_pass_cnt", pass_cnt, (i >= 7) ? 1 : 0);
            tick();
        end
        check("basic_done_pulse", done, 1);
        check("basic_done_busy", busy, 0);
        check("basic_done_pass_cnt", pass_cnt, 2);
        check("basic_done_dout", dout, 3);
        tick();
        check("basic_idle_done", done, 0);
        check("basic_idle_dout", dout, 3);
        check("basic_idle_pass_cnt", pass_cnt, 2);
        check("basic_idle_mode", mode, 0);

        // Rejected starts: lo == hi, then passes == 0
        lo = 5'd7; hi = 5'd7; passes = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("rej1_err", err, 1);
        check("rej1_busy", busy, 0);
        check("rej1_dout", dout, 3);
        tick();
        check("rej1_err_clear", err, 0);
        lo = 5'd0; hi = 5'd5; passes = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("rej2_err", err, 1);
        check("rej2_busy", busy, 0);
        check("rej2_dout", dout, 3);
        tick();
        check("rej2_err_clear", err, 0);
        check("rej2_busy_idle", busy, 0);

        // Full-range sweep with a 4-cycle hold at dout=10
        lo = 5'd0; hi = 5'd31; passes = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        check("hold_first", dout, 0);
        repeat (10) begin
            tick();
            n++;
        end
        check("hold_at10", dout, 10);
        hold = 1'b1;
        repeat (4) begin
            tick();
            n++;
            check("hold_frozen_dout", dout, 10);
            check("hold_busy", busy, 1);
        end
        hold = 1'b0;
        max_dout = 10;
        while (!done && n < 200) begin
            tick();
            n++;
            if (int'(dout) > max_dout) max_dout = int'(dout);
        end
        check("hold_done", done, 1);
        check("hold_length", n, 67);
        check("hold_max_dout", max_dout, 31);
        check("hold_pass_cnt", pass_cnt, 1);
        check("hold_final_dout", dout, 0);
        tick();

        // Start ignored mid-sweep, then reset during DOWN
        lo = 5'd2; hi = 5'd9; passes = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ign_pre", dout, 4);
        lo = 5'd0; hi = 5'd20; passes = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_dout", dout, 5);
        check("ign_err", err, 0);
        check("ign_busy", busy, 1);
        repeat (5) tick();
        check("ign_hi_kept", dout, 8);
        check("ign_mode_down", mode, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_dout", dout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_mode", mode, 0);
        check("midrst_pass_cnt", pass_cnt, 0);
        tick();
        check("midrst_idle_busy", busy, 0);

        // Back-to-back with start held high
        lo = 5'd1; hi = 5'd2; passes = 4'd1; start = 1'b1;
        tick();
        check("b2b_d0", dout, 1);
        check("b2b_busy", busy, 1);
        tick();
        check("b2b_d1", dout, 2);
        tick();
        check("b2b_d2", dout, 1);
        check("b2b_mode", mode, 1);
        tick();
        check("b2b_done", done, 1);
        check("b2b_done_busy", busy, 0);
        tick();
        check("b2b_idle_done", done, 0);
        check("b2b_idle_busy", busy, 0);
        tick();
        start = 1'b0;
        check("b2b_restart_dout", dout, 1);
        check("b2b_restart_busy", busy, 1);
        check("b2b_restart_pass_cnt", pass_cnt, 0);
        tick();
        tick();
        tick();
        check("b2b_done2", done, 1);
        tick();

`ifdef UPDOWN_SWEEP_ABORT_EN
        // Abort at dout=5 in the first pass, then abort combined with hold
        lo = 5'd0; hi = 5'd8; passes = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort_pre", dout, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_dout", dout, 5);
        check("abort_pass_cnt", pass_cnt, 0);
        tick();
        check("abort_done_clear", done, 0);
        lo = 5'd0; hi = 5'd8; passes = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        hold = 1'b1; abort = 1'b1;
        tick();
        hold = 1'b0; abort = 1'b0;
        check("abort_hold_done", done, 1);
        check("abort_hold_busy", busy, 0);
        check("abort_hold_dout", dout, 1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
